timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Parametrised multi-channel successor to the single stopwatch/watch pair.
- Provides NUM_CH independent timer channels. Each channel can count up (stopwatch) or count down (countdown timer with an expiry flag), and has its own lap-capture FIFO.
- Sits between the debounced, mode-gated button pulses and the FND controller.
- Outputs the selected channel's time on the same packed 24-bit bus {hour[4:0], min[5:0], sec[5:0], msec[6:0]} (msec is in 10 ms units, 0..99).

Parameters:
- NUM_CH, 4: number of timer channels, 1..8.
- TICK_DIV, 1_000_000: clk cycles per 10 ms tick (100 MHz).
- LAP_DEPTH, 4: lap FIFO entries per channel, power of two, 2..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- i_ch_sel  in  $clog2(NUM_CH) (min 1)  channel that receives commands and is displayed.
- i_run_p  in  1  one-cycle pulse; toggles run/stop of the selected channel.
- i_clear_p  in  1  one-cycle pulse; clears/loads the selected channel.
- i_lap_p  in  1  one-cycle pulse; pushes the selected channel's current time into its lap FIFO.
- i_lap_rd_p  in  1  one-cycle pulse; pops the head of the selected channel's lap FIFO.
- i_mode  in  1  direction latched at clear: 0 = count-up, 1 = countdown.
- i_preload  in  24  packed time loaded at clear.
- o_time  out  24  live time of the selected channel.
- o_lap  out  24  lap FIFO head of the selected channel; 0 when empty.
- o_lap_cnt  out  $clog2(LAP_DEPTH+1)  lap FIFO occupancy of the selected channel.
- o_running  out  NUM_CH  per-channel run state.
- o_expired  out  NUM_CH  per-channel sticky expiry flag.
- o_tick  out  1  one-cycle 10 ms tick strobe.

Behaviour:
- Reset (reset==0 at a clk edge):
  - prescaler = 0; every channel IDLE, count-up, time 0, FIFO empty.
  - All outputs 0.
- Prescaler: counts 0..TICK_DIV-1. o_tick = 1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- Per-channel FSM states: IDLE, RUN, PAUSE, EXPIRED. o_running=1 only in RUN.
  - IDLE, run -> RUN.
  - RUN, run -> PAUSE.
  - PAUSE, run -> RUN.
  - EXPIRED, run -> ignored.
  - Any state, clear -> IDLE.
  - RUN with countdown reaching 0 -> EXPIRED.
  - RUN or PAUSE entered with countdown time already 0 -> EXPIRED on the next cycle.
- Clear:
  - time <= i_preload with each field saturated: hour>23 -> 23, min/sec>59 -> 59, msec>99 -> 99.
  - direction <= i_mode; lap FIFO emptied; expired cleared.
- Count-up, per tick while RUN: msec+1. Carries at 99->0, 59->0, 59->0; hour 23->0 (full wrap to 00:00:00.00).
- Countdown, per tick while RUN: msec-1 with borrows (0->99, 0->59, 0->59, hour-1).
  - The tick that produces 00:00:00.00 sets EXPIRED and o_expired.
  - Time then holds at 0 until clear.
- Command priority per cycle, selected channel only: clear > run > lap > lap_rd. Lower-priority pulses in that cycle are dropped.
- Tick coinciding with a command:
  - Clear wins; no tick is applied to the loaded value.
  - Run toggle: the tick uses the pre-command state.
  - Lap captures the pre-tick time.
- Lap FIFO:
  - Push is accepted in RUN or PAUSE only; ignored in IDLE and EXPIRED.
  - Push when full overwrites the oldest entry; o_lap_cnt stays LAP_DEPTH.
  - Pop when empty is ignored.
  - o_lap and o_lap_cnt are combinational from the head pointer and count registers.
- Non-selected channels keep counting on every tick; commands never affect them.
- Latency:
  - Time and state registers update on the clk edge after the tick or command cycle.
  - o_time, o_lap and o_lap_cnt follow i_ch_sel combinationally in the same cycle.
  - i_ch_sel >= NUM_CH: o_time, o_lap, o_lap_cnt read 0 and commands are ignored.
- Reset mid-operation: full reset as above; any pending pulse in that cycle is ignored.

Decomposition:
- Package timer_pkg:
  - Field widths: 5/6/6/7, and TIME_W = 24.
  - Limit constants: MSEC_MAX 99, SEC_MAX 59, MIN_MAX 59, HOUR_MAX 23.
  - Channel state enum.
  - Pack/unpack and saturate functions.
- Sub-module timer_channel: FSM, up/down counter and lap FIFO for one channel. Instantiated NUM_CH times by generate.
- The prescaler, command decode and output mux stay in timer_bank.

Test Plan (TICK_DIV=2, NUM_CH=4, LAP_DEPTH=4):
- Hour wrap: ch0 clear with mode 0, preload 23:59:59.99; run; one tick -> o_time 00:00:00.00, o_running[0]=1.
- Countdown expiry: ch1 mode 1, preload 00:00:01.00; run; after 100 ticks -> o_time 0, o_expired[1]=1, o_running[1]=0. 10 more ticks -> still 0. Clear -> o_expired[1]=0.
- Lap overflow: ch2 running; 5 laps at times t1..t5 -> o_lap_cnt 4, o_lap = t2. Four pops -> t2..t5 in order, then o_lap_cnt 0 and o_lap 0. Fifth pop -> no change.
- Independence and priority: ch0 running; select ch3; clear+run+lap in one cycle -> ch3 IDLE with empty FIFO; ch0 keeps incrementing; o_running = 4'b0001.
- Saturation and zero preload: preload {31,63,63,127} in mode 1 -> 23:59:59.99. Preload 0 in mode 1, then run -> EXPIRED next cycle.
- Reset: reset low for one edge mid-run on all channels -> all outputs 0, every channel IDLE, prescaler restarts (first o_tick after TICK_DIV cycles).

Source files
------------

// File: rtl/timer_pkg.sv
// Shared time-field layout, limits, channel state encoding and helpers for the timer bank.
package timer_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MSEC_W = 7;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W + MSEC_W;

  localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_PAUSE,
    CH_EXPIRED
  } ch_state_e;

  // Field order matches the packed display bus {hour, min, sec, msec}.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

  function automatic time_t unpack_time(input logic [TIME_W-1:0] bus);
    return time_t'(bus);
  endfunction

  function automatic logic [TIME_W-1:0] pack_time(input time_t t);
    return TIME_W'(t);
  endfunction

  function automatic time_t saturate_time(input time_t t);
    time_t r;
    r.hour = (t.hour > HOUR_MAX) ? HOUR_MAX : t.hour;
    r.min  = (t.min  > MIN_MAX)  ? MIN_MAX  : t.min;
    r.sec  = (t.sec  > SEC_MAX)  ? SEC_MAX  : t.sec;
    r.msec = (t.msec > MSEC_MAX) ? MSEC_MAX : t.msec;
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: run/pause/expiry FSM, up/down time-of-day counter and lap FIFO.
module timer_channel
  import timer_pkg::*;
#(
  parameter  int LAP_DEPTH = 4,
  localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic              lap_i,
  input  logic              lap_rd_i,
  input  logic              mode_i,
  input  logic [TIME_W-1:0] preload_i,
  output logic [TIME_W-1:0] time_o,
  output logic [TIME_W-1:0] lap_o,
  output logic [CNT_W-1:0]  lap_cnt_o,
  output logic              running_o,
  output logic              expired_o
);

  localparam int PTR_W = $clog2(LAP_DEPTH);

  ch_state_e         state_q, state_d;
  time_t             time_q, time_d;
  logic              dir_q, dir_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push;
  logic              active;
  logic [TIME_W-1:0] lap_mem [LAP_DEPTH];

  function automatic time_t time_inc(input time_t t);
    time_t r = t;
    if (t.msec != MSEC_MAX) r.msec = t.msec + 1'b1;
    else begin
      r.msec = '0;
      if (t.sec != SEC_MAX) r.sec = t.sec + 1'b1;
      else begin
        r.sec = '0;
        if (t.min != MIN_MAX) r.min = t.min + 1'b1;
        else begin
          r.min  = '0;
          r.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Only called with a non-zero time, so the hour borrow never underflows.
  function automatic time_t time_dec(input time_t t);
    time_t r = t;
    if (t.msec != '0) r.msec = t.msec - 1'b1;
    else begin
      r.msec = MSEC_MAX;
      if (t.sec != '0) r.sec = t.sec - 1'b1;
      else begin
        r.sec = SEC_MAX;
        if (t.min != '0) r.min = t.min - 1'b1;
        else begin
          r.min  = MIN_MAX;
          r.hour = t.hour - 1'b1;
        end
      end
    end
    return r;
  endfunction

  assign active = (state_q == CH_RUN) || (state_q == CH_PAUSE);
  assign push   = lap_i && active && !clear_i;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    dir_d   = dir_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = CH_IDLE;
      time_d  = saturate_time(unpack_time(preload_i));
      dir_d   = mode_i;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end else begin
      if (state_q == CH_RUN && tick_i) begin
        if (!dir_q)               time_d = time_inc(time_q);
        else if (time_q != '0)    time_d = time_dec(time_q);
      end
      if (run_i) begin
        case (state_q)
          CH_IDLE:  state_d = CH_RUN;
          CH_RUN:   state_d = CH_PAUSE;
          CH_PAUSE: state_d = CH_RUN;
          default:  state_d = state_q;
        endcase
      end
      // Covers both a countdown tick landing on zero and running/pausing from a zero load.
      if (active && dir_q && time_d == '0) state_d = CH_EXPIRED;
      if (push) begin
        wr_d = wr_q + 1'b1;
        if (cnt_q == CNT_W'(LAP_DEPTH)) rd_d = rd_q + 1'b1;
        else                            cnt_d = cnt_q + 1'b1;
      end else if (lap_rd_i && cnt_q != '0) begin
        rd_d  = rd_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= CH_IDLE;
      time_q  <= '0;
      dir_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      dir_q   <= dir_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_ni && push) lap_mem[wr_q] <= pack_time(time_q);
  end

  assign time_o    = pack_time(time_q);
  assign lap_o     = (cnt_q == '0) ? '0 : lap_mem[rd_q];
  assign lap_cnt_o = cnt_q;
  assign running_o = (state_q == CH_RUN);
  assign expired_o = (state_q == CH_EXPIRED);

endmodule

// File: rtl/timer_bank.sv
// Multi-channel stopwatch/countdown bank: 10 ms prescaler, command decode and display mux.
module timer_bank
  import timer_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int TICK_DIV  = 1_000_000,
  parameter  int LAP_DEPTH = 4,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  i_ch_sel,
  input  logic              i_run_p,
  input  logic              i_clear_p,
  input  logic              i_lap_p,
  input  logic              i_lap_rd_p,
  input  logic              i_mode,
  input  logic [TIME_W-1:0] i_preload,
  output logic [TIME_W-1:0] o_time,
  output logic [TIME_W-1:0] o_lap,
  output logic [CNT_W-1:0]  o_lap_cnt,
  output logic [NUM_CH-1:0] o_running,
  output logic [NUM_CH-1:0] o_expired,
  output logic              o_tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick;
  logic [TIME_W-1:0] ch_time [NUM_CH];
  logic [TIME_W-1:0] ch_lap  [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt  [NUM_CH];

  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  assign o_tick = tick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
      logic sel_hit;
      logic clr_c, run_c, lap_c, rd_c;

      // Priority clear > run > lap > lap_rd; an out-of-range select hits no channel.
      assign sel_hit = (i_ch_sel == SEL_W'(gi));
      assign clr_c   = sel_hit && i_clear_p;
      assign run_c   = sel_hit && i_run_p && !i_clear_p;
      assign lap_c   = sel_hit && i_lap_p && !i_run_p && !i_clear_p;
      assign rd_c    = sel_hit && i_lap_rd_p && !i_lap_p && !i_run_p && !i_clear_p;

      timer_channel #(
        .LAP_DEPTH(LAP_DEPTH)
      ) u_ch (
        .clk       (clk),
        .rst_ni    (reset),
        .tick_i    (tick),
        .clear_i   (clr_c),
        .run_i     (run_c),
        .lap_i     (lap_c),
        .lap_rd_i  (rd_c),
        .mode_i    (i_mode),
        .preload_i (i_preload),
        .time_o    (ch_time[gi]),
        .lap_o     (ch_lap[gi]),
        .lap_cnt_o (ch_cnt[gi]),
        .running_o (o_running[gi]),
        .expired_o (o_expired[gi])
      );
    end
  endgenerate

  always_comb begin
    o_time    = '0;
    o_lap     = '0;
    o_lap_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_ch_sel == SEL_W'(k)) begin
        o_time    = ch_time[k];
        o_lap     = ch_lap[k];
        o_lap_cnt = ch_cnt[k];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised + directed bench for timer_bank; a centisecond-count model feeds a scoreboard queue.
module tb_timer_bank;

  localparam int NCH = 4;
  localparam int TD  = 2;
  localparam int LD  = 4;
  localparam int DAY = 24 * 360000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_sel;
  logic        run_p, clear_p, lap_p, lap_rd_p, mode;
  logic [23:0] preload;
  logic [23:0] o_time, o_lap;
  logic [2:0]  o_lap_cnt;
  logic [3:0]  o_running, o_expired;
  logic        o_tick;

  timer_bank #(.NUM_CH(NCH), .TICK_DIV(TD), .LAP_DEPTH(LD)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_ch_sel   (ch_sel),
    .i_run_p    (run_p),
    .i_clear_p  (clear_p),
    .i_lap_p    (lap_p),
    .i_lap_rd_p (lap_rd_p),
    .i_mode     (mode),
    .i_preload  (preload),
    .o_time     (o_time),
    .o_lap      (o_lap),
    .o_lap_cnt  (o_lap_cnt),
    .o_running  (o_running),
    .o_expired  (o_expired),
    .o_tick     (o_tick)
  );

  always #5 clk = ~clk;

  // Reference model: time as plain centiseconds since midnight, FIFO as a queue.
  int m_t   [NCH];
  int m_st  [NCH];
  bit m_dir [NCH];
  int m_q   [NCH][$];
  int m_pres;

  typedef struct {
    logic [23:0] tm;
    logic [23:0] lap;
    logic [2:0]  cnt;
    logic [3:0]  run;
    logic [3:0]  exp;
    logic        tick;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;

  function automatic int sat_cs(input logic [23:0] p);
    int h, m, s, c;
    h = int'(p[23:19]); if (h > 23) h = 23;
    m = int'(p[18:13]); if (m > 59) m = 59;
    s = int'(p[12:7]);  if (s > 59) s = 59;
    c = int'(p[6:0]);   if (c > 99) c = 99;
    return ((h * 60 + m) * 60 + s) * 100 + c;
  endfunction

  function automatic logic [23:0] to_bus(input int t);
    int h, m, s, c;
    c = t % 100;
    s = (t / 100) % 60;
    m = (t / 6000) % 60;
    h = t / 360000;
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  function automatic logic [23:0] hms(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_t[c] = 0; m_st[c] = S_IDLE; m_dir[c] = 1'b0; m_q[c].delete();
    end
    m_pres = 0;
  endtask

  task automatic model_edge(input logic [1:0] sel, input bit clr, input bit run, input bit lap,
                            input bit rd, input bit md, input logic [23:0] pre, input bit rstn);
    bit tick;
    if (!rstn) begin
      model_reset();
      return;
    end
    tick = (m_pres == TD - 1);
    for (int c = 0; c < NCH; c++) begin
      bit hit, active;
      int ps, nt;
      hit = (int'(sel) == c);
      if (hit && clr) begin
        m_t[c] = sat_cs(pre); m_dir[c] = md; m_st[c] = S_IDLE; m_q[c].delete();
        continue;
      end
      ps = m_st[c];
      nt = m_t[c];
      if (ps == S_RUN && tick) nt = m_dir[c] ? ((nt > 0) ? nt - 1 : 0) : (nt + 1) % DAY;
      if (hit && run) begin
        if (ps == S_IDLE || ps == S_PAUSE) m_st[c] = S_RUN;
        else if (ps == S_RUN)              m_st[c] = S_PAUSE;
      end
      active = (ps == S_RUN || ps == S_PAUSE);
      if (active && m_dir[c] && nt == 0) m_st[c] = S_EXP;
      if (hit && !run && lap) begin
        if (active) begin
          m_q[c].push_back(m_t[c]);
          if (m_q[c].size() > LD) void'(m_q[c].pop_front());
        end
      end else if (hit && !run && rd && m_q[c].size() > 0) begin
        void'(m_q[c].pop_front());
      end
      m_t[c] = nt;
    end
    m_pres = tick ? 0 : m_pres + 1;
  endtask

  task automatic push_expect(input logic [1:0] sel);
    exp_t e;
    int s;
    s = int'(sel);
    e.tm   = to_bus(m_t[s]);
    e.lap  = (m_q[s].size() > 0) ? to_bus(m_q[s][0]) : 24'h0;
    e.cnt  = 3'(m_q[s].size());
    for (int c = 0; c < NCH; c++) begin
      e.run[c] = (m_st[c] == S_RUN);
      e.exp[c] = (m_st[c] == S_EXP);
    end
    e.tick = (m_pres == TD - 1);
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  logic [1:0] cur_sel = 2'd0;

  task automatic drive(input logic [1:0] sel, input bit clr, input bit run, input bit lap,
                       input bit rd, input bit md, input logic [23:0] pre, input bit rstn);
    ch_sel = sel; clear_p = clr; run_p = run; lap_p = lap; lap_rd_p = rd;
    mode = md; preload = pre; reset = rstn;
    push_expect(sel);
    @(posedge clk);
    model_edge(sel, clr, run, lap, rd, md, pre, rstn);
    cyc++;
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) drive(cur_sel, 0, 0, 0, 0, 0, 24'h0, 1);
  endtask

  task automatic cmd_clear(input logic [1:0] sel, input bit md, input logic [23:0] pre);
    cur_sel = sel;
    drive(sel, 1, 0, 0, 0, md, pre, 1);
  endtask

  task automatic cmd_run(input logic [1:0] sel);
    cur_sel = sel;
    drive(sel, 0, 1, 0, 0, 0, 24'h0, 1);
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] want, input int c);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, want);
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("time",    o_time,            e.tm,            e.cyc);
        chk("lap",     o_lap,             e.lap,           e.cyc);
        chk("lap_cnt", 24'(o_lap_cnt),    24'(e.cnt),      e.cyc);
        chk("running", 24'(o_running),    24'(e.run),      e.cyc);
        chk("expired", 24'(o_expired),    24'(e.exp),      e.cyc);
        chk("tick",    24'(o_tick),       24'(e.tick),     e.cyc);
        $display("cyc %0d sel %0d time %h lap %h cnt %0d run %b exp %b tick %b",
                 e.cyc, ch_sel, o_time, o_lap, o_lap_cnt, o_running, o_expired, o_tick);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; ch_sel = '0; run_p = 0; clear_p = 0; lap_p = 0; lap_rd_p = 0;
    mode = 0; preload = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // Reset state, then hour wrap on ch0.
    nop(2);
    cmd_clear(2'd0, 0, hms(23, 59, 59, 99));
    cmd_run(2'd0);
    nop(3);

    // Countdown expiry on ch1: one second of ticks, hold at zero, then clear.
    cmd_clear(2'd1, 1, hms(0, 0, 1, 0));
    cmd_run(2'd1);
    nop(100 * TD + 4);
    nop(10 * TD);
    cmd_clear(2'd1, 1, hms(0, 0, 1, 0));
    nop(2);

    // Lap overflow on ch2: five pushes, then five pops.
    cmd_clear(2'd2, 0, 24'h0);
    cmd_run(2'd2);
    for (int i = 0; i < 5; i++) begin
      nop(3);
      drive(2'd2, 0, 0, 1, 0, 0, 24'h0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      nop(1);
      drive(2'd2, 0, 0, 0, 1, 0, 24'h0, 1);
    end
    nop(2);

    // Priority on ch3 while others run: clear + run + lap in one cycle.
    cmd_run(2'd1);
    cmd_run(2'd2);
    cur_sel = 2'd3;
    drive(2'd3, 1, 1, 1, 1, 0, hms(1, 2, 3, 4), 1);
    nop(4);

    // Saturation, then zero countdown load expiring right after run.
    cmd_clear(2'd3, 1, 24'hFFFFFF);
    nop(2);
    cmd_clear(2'd3, 1, 24'h0);
    cmd_run(2'd3);
    nop(3);

    // Randomised traffic across all channels.
    for (int i = 0; i < 2500; i++) begin
      logic [1:0]  s;
      bit          clr, run, lap, rd, md, rstn;
      logic [23:0] pre;
      s    = 2'($urandom_range(0, 3));
      clr  = ($urandom_range(0, 39) == 0);
      run  = ($urandom_range(0, 9) == 0);
      lap  = ($urandom_range(0, 5) == 0);
      rd   = ($urandom_range(0, 5) == 0);
      md   = ($urandom_range(0, 1) == 1);
      rstn = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 1) == 0) pre = 24'($urandom);
      else                           pre = {17'd0, 7'($urandom_range(0, 20))};
      cur_sel = s;
      drive(s, clr, run, lap, rd, md, pre, rstn);
    end

    // Reset mid-run with every channel running and a pulse pending.
    for (int c = 0; c < NCH; c++) begin
      cmd_clear(2'(c), 0, hms(0, 0, 0, c));
      cmd_run(2'(c));
    end
    nop(3);
    drive(2'd0, 0, 1, 1, 0, 0, 24'h0, 0);
    nop(TD + 3);

    @(negedge clk);
    #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
